// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mult_pkg;

    // Controller states of the multiplier
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Operand width used when the instantiating design does not override it
    localparam int DEFAULT_SIZE = 8;

endpackage : mult_pkg

// File: rtl/ripple_adder.sv
// Parameterised ripple-carry adder, purely combinational.
// Used by the multiplier to add the multiplicand into the upper half of
// its accumulator once per iteration.
module RippleAdder #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] sum,
    output logic            cout
);

    logic [SIZE:0] carry;

    assign carry[0] = cin;

    // One full-adder cell per bit; carry ripples from LSB to MSB
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[SIZE];

endmodule : RippleAdder

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned SIZE x SIZE -> 2*SIZE multiplier, one multiplier bit
// per clock using a ripple-carry adder and a shifting accumulator.
// Optional build macro: MULT_EARLY_TERM_EN -- finish as soon as the
// remaining multiplier bits are all zero (same results, shorter latency).
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] product
);

    localparam int CNT_W = $clog2(SIZE + 1);

    state_t              state_reg;
    logic [SIZE-1:0]     mcand_reg;
    logic [2*SIZE-1:0]   acc_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [2*SIZE-1:0]   product_reg;

    // Upper half of the accumulator is the running partial product, lower
    // half holds the not-yet-consumed multiplier bits (LSB first).
    logic [SIZE-1:0]     hi;
    logic [SIZE-1:0]     lo;
    logic [SIZE-1:0]     sum;
    logic                cout;
    logic [2*SIZE-1:0]   acc_next;
    logic [2*SIZE-1:0]   product_next;
    logic                finish;

    assign hi = acc_reg[2*SIZE-1:SIZE];
    assign lo = acc_reg[SIZE-1:0];

    RippleAdder #(
        .SIZE (SIZE)
    ) u_adder (
        .a    (hi),
        .b    (mcand_reg),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Add-or-skip then shift right by one; the carry becomes the new MSB so
    // the partial product can never overflow.
    always_comb begin
        if (lo[0]) begin
            acc_next = {cout, sum, lo[SIZE-1:1]};
        end else begin
            acc_next = {1'b0, hi, lo[SIZE-1:1]};
        end
    end

`ifdef MULT_EARLY_TERM_EN
    logic [CNT_W-1:0] cnt_m1;
    logic [SIZE-1:0]  rem_bits;

    // After this cycle's shift, cnt-1 multiplier bits remain at the bottom
    // of the accumulator; if they are all zero the remaining iterations
    // would only shift, so apply those shifts at once.
    always_comb begin
        cnt_m1       = cnt_reg - CNT_W'(1);
        rem_bits     = acc_next[SIZE-1:0] & ~({SIZE{1'b1}} << cnt_m1);
        finish       = (cnt_reg == CNT_W'(1)) || (rem_bits == '0);
        product_next = acc_next >> cnt_m1;
    end
`else
    // Fixed latency: always run all SIZE iterations
    always_comb begin
        finish       = (cnt_reg == CNT_W'(1));
        product_next = acc_next;
    end
`endif

    // Controller, datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg <= a;
                        acc_reg   <= {{SIZE{1'b0}}, b};
                        cnt_reg   <= CNT_W'(SIZE);
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (finish) begin
                        product_reg <= product_next;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (SIZE=8) using a scoreboard
// of expected products and expected done cycles.
module tb_shift_add_multiplier;

    localparam int SIZE = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [SIZE-1:0]   a;
    logic [SIZE-1:0]   b;
    logic              busy;
    logic              done;
    logic [2*SIZE-1:0] product;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [2*SIZE-1:0] prod;
        int                done_cyc;
        int                a_val;
        int                b_val;
    } exp_t;

    exp_t        sb_q[$];
    logic [2*SIZE-1:0] held_prod = '0;

    shift_add_multiplier #(
        .SIZE (SIZE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Expected number of cycles from acceptance to done
    function automatic int exp_latency(input logic [SIZE-1:0] bv);
        int msb;
`ifdef MULT_EARLY_TERM_EN
        msb = 0;
        for (int i = 0; i < SIZE; i++) if (bv[i]) msb = i + 1;
        return (msb == 0) ? 1 : msb;
`else
        msb = int'(bv);
        return SIZE + 0 * msb;
`endif
    endfunction

    // Push an expectation for an operation accepted at the next rising edge
    task automatic push_exp(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv);
        exp_t e;
        e.prod     = (2*SIZE)'(av) * (2*SIZE)'(bv);
        e.done_cyc = cyc + 1 + exp_latency(bv);
        e.a_val    = int'(av);
        e.b_val    = int'(bv);
        sb_q.push_back(e);
    endtask

    // Monitor: compare every done pulse against the scoreboard head and check
    // that product holds between pulses.
    always @(negedge clk) begin
        if (rst) begin
            held_prod = '0;
        end else if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("product", 32'(product), 32'(e.prod));
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                check("busy_in_done", 32'(busy), 32'd0);
                $display("op a=%0d b=%0d -> product=%0d at cycle %0d", e.a_val, e.b_val, product, cyc);
            end
            held_prod = product;
        end else if (product !== held_prod) begin
            check("product_hold", 32'(product), 32'(held_prod));
            held_prod = product;
        end
    end

    // Wait (bounded) for the scoreboard to drain
    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            check({tag, "_timeout"}, 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic run_op(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv);
        @(negedge clk); #1;
        a     = av;
        b     = bv;
        start = 1'b1;
        push_exp(av, bv);
        @(negedge clk); #1;
        start = 1'b0;
        a     = $urandom_range(0, 255);
        b     = $urandom_range(0, 255);
        wait_drain("op");
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        rst = 1'b0;

        run_op(8'd13, 8'd11);
        run_op(8'd255, 8'd255);
        run_op(8'd0, 8'd200);
        run_op(8'd77, 8'd0);
        run_op(8'd200, 8'd3);
        run_op(8'd128, 8'd129);

        // Start held high across the run, a changed mid-run, then a
        // back-to-back operation accepted in the done cycle.
        @(negedge clk); #1;
        a = 8'd3; b = 8'd5; start = 1'b1;
        push_exp(8'd3, 8'd5);
        repeat (3) @(negedge clk);
        #1;
        a = 8'd9;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("held_start_done_seen", 32'(done), 32'd1);
        b = 8'd9;
        push_exp(8'd9, 8'd9);
        @(negedge clk); #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_drain("b2b");

        // Reset at E4 of a long operation aborts it
        @(negedge clk); #1;
        a = 8'd100; b = 8'd100; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        repeat (10) @(negedge clk);
        #1;
        check("abort_no_late_done_busy", 32'(busy), 32'd0);
        run_op(8'd2, 8'd3);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_add_multiplier
